// File: rtl/onehot_dispatch.sv
// onehot_dispatch: buffers 2-bit request codes in a 2-entry FIFO and replays
// each one as a one-hot strobe on y, held for HOLD cycles, followed by a
// single all-zero gap cycle before the next request.
//
// Handshake: a request is accepted on a rising edge where in_valid and
// in_ready are both high. in_ready depends only on the registered FIFO
// count, so a pop in the same cycle never opens room for a push. The source
// must hold in_code stable until it is accepted.
module onehot_dispatch #(
  parameter int unsigned HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] in_code,
  output logic       in_ready,
  output logic [3:0] y,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] y_q, y_d;

  logic [1:0] mem_q [2];
  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] count_q;
  logic [1:0] head;
  logic       push, pop;

  assign in_ready  = (count_q < 2'd2);
  assign push      = in_valid && in_ready;
  assign head      = mem_q[rd_ptr_q];
  assign y         = y_q;
  assign busy      = (state_q != ST_IDLE) || (count_q != 2'd0);
  assign dbg_state = state_q;

  // FIFO storage, pointers and occupancy; reset flushes any queued codes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_code;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Dispatcher state, hold counter and registered one-hot output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= 8'd0;
      y_q     <= 4'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      y_q     <= y_d;
    end
  end

  // Next-state logic: pop the head from IDLE or GAP, count down in DRIVE
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    y_d     = y_q;
    pop     = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        y_d = 4'd0;
        if (count_q != 2'd0) begin
          pop     = 1'b1;
          y_d     = 4'(4'b0001 << head);
          hold_d  = HOLD_M1;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (hold_q == 8'd0) begin
          done    = 1'b1;
          y_d     = 4'd0;
          state_d = ST_GAP;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      ST_GAP: begin
        y_d = 4'd0;
        if (count_q != 2'd0) begin
          pop     = 1'b1;
          y_d     = 4'(4'b0001 << head);
          hold_d  = HOLD_M1;
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        y_d     = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
